// File: rtl/march_bist.sv
// March C- BIST controller driving a single-port RAM and reporting first-failure diagnostics.
// Optional feature: define BIST_STOP_ON_FAIL_EN to end the run at the first mismatching read.
module march_bist #(
    parameter int ADR_SIZE  = 4,
    parameter int DATA_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [ADR_SIZE-1:0]  adress,
    inout  wire  [DATA_SIZE-1:0] data,
    output logic                 wr_en,
    output logic                 read_en,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [ADR_SIZE-1:0]  fail_adr,
    output logic [DATA_SIZE-1:0] fail_data,
    output logic [2:0]           fail_elem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADR_SIZE-1:0] ADR_LAST = '1;

`ifdef BIST_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    state_t                 state_q, state_d;
    logic [2:0]             elem_q, elem_d;
    logic [ADR_SIZE-1:0]    adr_q, adr_d;
    logic                   wph_q, wph_d;
    logic                   fail_q, fail_d;
    logic [ADR_SIZE-1:0]    fail_adr_q, fail_adr_d;
    logic [DATA_SIZE-1:0]   fail_data_q, fail_data_d;
    logic [2:0]             fail_elem_q, fail_elem_d;

    logic running, elem_down, is_wr, is_rd, wr_bg, rd_bg, last_adr, mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            elem_q      <= '0;
            adr_q       <= '0;
            wph_q       <= 1'b0;
            fail_q      <= 1'b0;
            fail_adr_q  <= '0;
            fail_data_q <= '0;
            fail_elem_q <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            adr_q       <= adr_d;
            wph_q       <= wph_d;
            fail_q      <= fail_d;
            fail_adr_q  <= fail_adr_d;
            fail_data_q <= fail_data_d;
            fail_elem_q <= fail_elem_d;
        end
    end

    // E0 is write-only and E5 read-only; E1-E4 alternate read (wph=0) then write (wph=1).
    always_comb begin
        running   = (state_q == RUN);
        elem_down = (elem_q == 3'd3) || (elem_q == 3'd4);
        is_wr     = running && ((elem_q == 3'd0) || wph_q);
        is_rd     = running && !is_wr;
        wr_bg     = (elem_q == 3'd1) || (elem_q == 3'd3);
        rd_bg     = (elem_q == 3'd2) || (elem_q == 3'd4);
        last_adr  = elem_down ? (adr_q == '0) : (adr_q == ADR_LAST);
        mismatch  = is_rd && (data != {DATA_SIZE{rd_bg}});
    end

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        adr_d       = adr_q;
        wph_d       = wph_q;
        fail_d      = fail_q;
        fail_adr_d  = fail_adr_q;
        fail_data_d = fail_data_q;
        fail_elem_d = fail_elem_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = RUN;
                    elem_d      = '0;
                    adr_d       = '0;
                    wph_d       = 1'b0;
                    fail_d      = 1'b0;
                    fail_adr_d  = '0;
                    fail_data_d = '0;
                    fail_elem_d = '0;
                end
            end
            RUN: begin
                if (mismatch) begin
                    fail_d = 1'b1;
                    if (!fail_q) begin
                        fail_adr_d  = adr_q;
                        fail_data_d = data;
                        fail_elem_d = elem_q;
                    end
                end
                if (STOP_ON_FAIL && mismatch) begin
                    state_d = DONE;
                    elem_d  = '0;
                    adr_d   = '0;
                    wph_d   = 1'b0;
                end else if (is_rd && (elem_q != 3'd5)) begin
                    wph_d = 1'b1;
                end else begin
                    wph_d = 1'b0;
                    if (last_adr) begin
                        if (elem_q == 3'd5) begin
                            state_d = DONE;
                            elem_d  = '0;
                            adr_d   = '0;
                        end else begin
                            elem_d = elem_q + 3'd1;
                            // E3 and E4 are the down elements and start at the top.
                            adr_d  = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADR_LAST : '0;
                        end
                    end else begin
                        adr_d = elem_down ? adr_q - 1'b1 : adr_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign adress    = running ? adr_q : '0;
    assign wr_en     = is_wr;
    assign read_en   = is_rd;
    assign data      = is_wr ? {DATA_SIZE{wr_bg}} : {DATA_SIZE{1'bz}};
    assign busy      = running;
    assign done      = (state_q == DONE);
    assign fail      = fail_q;
    assign fail_adr  = fail_adr_q;
    assign fail_data = fail_data_q;
    assign fail_elem = fail_elem_q;

endmodule

// File: tb/tb_march_bist.sv
// Scoreboard bench for march_bist: a reference March C- op list is queued at start
// and each bus cycle is popped and compared; an in-bench RAM model can plant a stuck bit.
module tb_march_bist;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int N  = 1 << AW;

`ifdef BIST_STOP_ON_FAIL_EN
    localparam bit STOP_EN = 1'b1;
`else
    localparam bit STOP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] adress;
    wire  [DW-1:0] data;
    logic          wr_en, read_en, busy, done, fail;
    logic [AW-1:0] fail_adr;
    logic [DW-1:0] fail_data;
    logic [2:0]    fail_elem;

    logic [DW-1:0] ram [N];
    logic          flt = 1'b0;
    logic [DW-1:0] rd_val;

    march_bist #(.ADR_SIZE(AW), .DATA_SIZE(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .adress(adress), .data(data),
        .wr_en(wr_en), .read_en(read_en), .busy(busy), .done(done), .fail(fail),
        .fail_adr(fail_adr), .fail_data(fail_data), .fail_elem(fail_elem)
    );

    always #5 clk = ~clk;

    // RAM model: combinational read, bit 3 of address 5 stuck at 1 when flt is set.
    assign rd_val = ram[adress] | ((flt && adress == 4'd5) ? 8'h08 : 8'h00);
    assign data   = read_en ? rd_val : {DW{1'bz}};
    for (genvar i = 0; i < DW; i++) begin : g_pu
        pullup (data[i]);
    end
    always @(posedge clk) if (wr_en) ram[adress] <= data;

    typedef struct packed {
        logic          wr;
        logic          rd;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } op_t;

    op_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ctl"}, {busy, done, fail, wr_en, read_en, adress}, 32'h0);
        check({tag, "_diag"}, {fail_elem, fail_adr, fail_data}, 32'h0);
        check({tag, "_busz"}, data, 32'hFF);
    endtask

    task automatic push_ops(input bit flt_i, output int n_wr, output int n_rd);
        logic [AW-1:0] a;
        n_wr = 0;
        n_rd = 0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < N; i++) begin
                a = (e == 3 || e == 4) ? AW'(N - 1 - i) : AW'(i);
                if (e > 0) begin
                    exp_q.push_back('{wr: 1'b0, rd: 1'b1, a: a,
                                      d: (e == 2 || e == 4) ? 8'hFF : 8'h00});
                    n_rd++;
                    if (STOP_EN && flt_i && e == 1 && a == 4'd5) return;
                end
                if (e < 5) begin
                    exp_q.push_back('{wr: 1'b1, rd: 1'b0, a: a,
                                      d: (e == 1 || e == 3) ? 8'hFF : 8'h00});
                    n_wr++;
                end
            end
        end
    endtask

    task automatic run(input bit flt_i, input int again_op, input int rst_op);
        int  op = 0;
        int  nwr = 0;
        int  nrd = 0;
        int  exp_wr, exp_rd, n_exp;
        op_t e;
        flt = flt_i;
        exp_q.delete();
        push_ops(flt_i, exp_wr, exp_rd);
        n_exp = exp_q.size();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_first_op", {busy, done}, 32'h2);
        check("diag_cleared", {fail, fail_elem, fail_adr, fail_data}, 32'h0);
        while (busy && op < 400) begin
            check("bus_excl", {31'b0, wr_en & read_en}, 32'h0);
            if (exp_q.size() == 0) begin
                check("extra_op", op, n_exp);
                break;
            end
            e = exp_q.pop_front();
            check($sformatf("op%0d_ctl", op), {wr_en, read_en, adress}, {e.wr, e.rd, e.a});
            if (wr_en) check($sformatf("op%0d_wdata", op), data, e.d);
            nwr += int'(wr_en);
            nrd += int'(read_en);
            start = (op == again_op);
            if (op == rst_op) begin
                rst_n = 1'b0;
                #1;
                check_reset("midrun_rst");
                @(negedge clk);
                rst_n = 1'b1;
                start = 1'b0;
                @(negedge clk);
                return;
            end
            @(negedge clk);
            op++;
        end
        start = 1'b0;
        check("op_count", op, n_exp);
        check("wr_count", nwr, exp_wr);
        check("rd_count", nrd, exp_rd);
        check("done_state", {busy, done}, 32'h1);
        check("idle_bus", {wr_en, read_en, adress}, 32'h0);
        check("idle_busz", data, 32'hFF);
        if (flt_i) begin
            check("fail_flag", fail, 1);
            check("fail_adr", fail_adr, 32'h5);
            check("fail_data", fail_data, 32'h08);
            check("fail_elem", fail_elem, 32'h1);
        end else begin
            check("fail_flag", fail, 0);
            check("fail_diag", {fail_elem, fail_adr, fail_data}, 32'h0);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset("idle");
        run(1'b0, -1, -1);
        run(1'b1, -1, -1);
        run(1'b0, 30, -1);
        run(1'b0, -1, 50);
        run(1'b0, -1, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/march_bist.md
Name: march_bist

Overview:
- BIST controller that sits directly upstream of the single-port BIST RAM (`mem`).
- Drives the RAM's address, data (bidirectional), wr_en and read_en pins.
- Runs a March C- sequence over every address and checks each read against the expected background.
- Reports pass/fail plus first-failure diagnostics to the test host.

Parameters:
- ADR_SIZE, 4, RAM address width; N = 2^ADR_SIZE words tested.
- DATA_SIZE, 8, RAM word width; backgrounds are all-0 and all-1.

Ports:
- clk  input  1  rising-edge clock, shared with the RAM.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin test; sampled only in IDLE or DONE.
- adress  output  ADR_SIZE  RAM address.
- data  inout  DATA_SIZE  RAM data bus; driven only while wr_en=1, else high-Z.
- wr_en  output  1  RAM write enable.
- read_en  output  1  RAM read enable.
- busy  output  1  test in progress.
- done  output  1  test finished; level, held until the next start.
- fail  output  1  sticky mismatch flag for the current run.
- fail_adr  output  ADR_SIZE  address of the first mismatch.
- fail_data  output  DATA_SIZE  word read at the first mismatch.
- fail_elem  output  3  march element index (0-5) of the first mismatch.

Behaviour:
- Reset: clock is clk; reset is rst_n, asynchronous, active-low.
- Reset values: state=IDLE; adress=0; wr_en=0; read_en=0; data=Z; busy=0; done=0; fail=0; fail_adr=0; fail_data=0; fail_elem=0.
- Reset mid-run: aborts immediately and releases the bus combinationally on rst_n low.
- States:
  - IDLE -> RUN on start=1.
  - RUN -> DONE after the last op.
  - DONE -> RUN on start=1; this clears fail, fail_adr, fail_data and fail_elem.
- start while busy=1 is ignored.
- March elements, run in order; up = 0..N-1, down = N-1..0:
  - E0 up(w0)
  - E1 up(r0,w1)
  - E2 up(r1,w0)
  - E3 down(r0,w1)
  - E4 down(r1,w0)
  - E5 up(r0)
- Op timing:
  - One op per clock cycle.
  - For a read-then-write pair, the read cycle is followed by the write cycle to the same address, then the address advances.
  - No idle cycles between elements.
  - Total = 10N op cycles (5N writes, 5N reads); N=16 gives 160.
- Cycle timing:
  - start sampled high at edge k -> busy=1 and first op driven in cycle k+1.
  - At the edge ending the final op, state=DONE: busy=0, done=1, bus idle.
- Write cycle: wr_en=1, read_en=0, data driven with the background (0 or {DATA_SIZE{1}}).
- Read cycle: read_en=1, wr_en=0, data=Z. The RAM read is combinational, so data is compared at the edge ending the read cycle.
- Bus rule: wr_en and read_en are never both 1.
- Outside RUN: adress=0, both enables 0, data=Z.
- Mismatch handling:
  - Any bit differs from expected -> fail=1.
  - On the first mismatch only, capture adress, the read word and the element index.
  - Later mismatches do not overwrite the diagnostics.
- Address boundaries: down elements end at address 0 and up elements end at N-1, with no wrap. The element counter alone sequences the elements.

Optional Feature:
- Macro: BIST_STOP_ON_FAIL_EN.
- Defined: the first mismatch aborts the run. At the edge ending the failing read, state=DONE, busy=0, done=1, fail=1, with diagnostics captured. The pending write for that address is not issued.
- Undefined: the run always completes all 10N ops; fail and diagnostics are sticky.

Test Plan:
- Fault-free RAM (`mem` #(4,8)), start pulse -> done rises exactly 160 cycles after the first op; fail=0; 80 wr_en cycles and 80 read_en cycles counted.
- RAM model with addr 5 bit 3 stuck-at-1 -> fail=1, fail_adr=4'h5, fail_data=8'h08, fail_elem=1.
  - Without macro: done at 160 cycles.
  - With BIST_STOP_ON_FAIL_EN: done after op 27, and no write to addr 5 in E1.
- Assert rst_n=0 at op 50 -> outputs return to reset values and data=Z the same cycle. A new start then produces a clean 160-cycle run.
- Pulse start again at op 30 while busy -> ignored; op sequence and the 160-cycle total are unchanged.
- Second start from DONE after a failing run -> fail and diagnostics cleared at the start edge; a fault-free run ends with fail=0.
- Continuous assertion check across all runs:
  - wr_en & read_en is never 1.
  - data is non-Z only while wr_en=1.
  - Address order is 0..15 in E0-E2 and E5, and 15..0 in E3-E4.
